// File: rtl/spi_frame_pkg.sv
// Shared constants and state encoding for the SPI frame receiver.
package spi_frame_pkg;

    localparam int unsigned FRAME_W = 16;

    localparam logic [7:0] ADDR_R   = 8'd1;
    localparam logic [7:0] ADDR_G   = 8'd2;
    localparam logic [7:0] ADDR_B   = 8'd3;
    localparam logic [7:0] DUTY_RST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        REJECT
    } state_t;

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses
// derived from the last synchroniser flop and one extra delay flop.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            dly   <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            dly   <= chain[SYNC_STAGES-1];
        end
    end

    assign dout = chain[SYNC_STAGES-1];
    assign rise = dout & ~dly;
    assign fall = ~dout & dly;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: synchronises sck/cs_n/mosi, assembles 16-bit frames and
// decodes them into RGB duty registers. Optional MISO echo: SPI_FRAME_RX_MISO_EN.
module spi_frame_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_W     = spi_frame_pkg::FRAME_W,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sck,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic [7:0]       pwm_val_r,
    output logic [7:0]       pwm_val_g,
    output logic [7:0]       pwm_val_b,
    output logic             pwm_en,
    output logic             wr_stb,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt
`ifdef SPI_FRAME_RX_MISO_EN
    ,
    output logic             spi_miso
`endif
);

    import spi_frame_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(FRAME_W + 2);
    localparam int unsigned      IDX_W    = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_W + 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    // cs_n chain resets to "asserted" so a cs_n already low at reset release
    // never looks like a fresh frame start.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .din(spi_sck), .dout(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n), .dout(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi), .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               cs_pend;
    logic [7:0]         frame_addr;
    logic [7:0]         frame_val;
    logic               addr_ok;
    logic               err_inc;

    assign frame_addr = shreg[FRAME_W-1 -: 8];
    assign frame_val  = shreg[7:0];
    assign addr_ok    = (frame_addr == ADDR_R) || (frame_addr == ADDR_G) || (frame_addr == ADDR_B);
    assign err_inc    = (state == REJECT) || ((state == COMMIT) && !addr_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            cs_pend   <= 1'b0;
            pwm_val_r <= DUTY_RST;
            pwm_val_g <= DUTY_RST;
            pwm_val_b <= DUTY_RST;
            pwm_en    <= 1'b0;
            wr_stb    <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            case (state)
                IDLE: begin
                    cs_pend <= 1'b0;
                    if (cs_fall || cs_pend) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        pwm_en  <= 1'b0;
                    end else begin
                        pwm_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    // cs_n rise wins over a coincident sck rise; that bit is dropped.
                    if (cs_rise) begin
                        state <= (bit_cnt == CNT_FULL) ? COMMIT : REJECT;
                    end else if (sck_rise) begin
                        if (bit_cnt < CNT_FULL)
                            shreg[bit_cnt[IDX_W-1:0]] <= mosi_s;
                        if (bit_cnt != CNT_OVR)
                            bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    state   <= IDLE;
                    pwm_en  <= 1'b1;
                    cs_pend <= cs_fall;
                    case (frame_addr)
                        ADDR_R: begin pwm_val_r <= frame_val; wr_stb <= 1'b1; end
                        ADDR_G: begin pwm_val_g <= frame_val; wr_stb <= 1'b1; end
                        ADDR_B: begin pwm_val_b <= frame_val; wr_stb <= 1'b1; end
                        default: ;
                    endcase
                end
                REJECT: begin
                    state   <= IDLE;
                    pwm_en  <= 1'b1;
                    cs_pend <= cs_fall;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (err_inc && (err_cnt != '1))
            err_cnt <= err_cnt + ERR_W'(1);
    end

`ifdef SPI_FRAME_RX_MISO_EN
    logic [FRAME_W-1:0] echo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo     <= '0;
            spi_miso <= 1'b0;
        end else begin
            if ((state == COMMIT) && addr_ok)
                echo <= shreg;
            case (state)
                IDLE:  spi_miso <= (cs_fall || cs_pend) ? echo[0] : 1'b0;
                SHIFT: begin
                    // bit_cnt already counts the bits sampled so far, so it
                    // indexes the next bit to present.
                    if (cs_rise)
                        spi_miso <= 1'b0;
                    else if (sck_fall)
                        spi_miso <= (bit_cnt < CNT_FULL) ? echo[bit_cnt[IDX_W-1:0]] : 1'b0;
                end
                default: spi_miso <= 1'b0;
            endcase
        end
    end

    logic [4:0] unused_sync;
    assign unused_sync = {sck_lvl, cs_lvl, mosi_rise, mosi_fall, 1'b0};
`else
    logic [4:0] unused_sync;
    assign unused_sync = {sck_lvl, cs_lvl, mosi_rise, mosi_fall, sck_fall};
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed plus randomized frame stimulus for spi_frame_rx, checked against a
// frame-level reference model of the duty registers, error count and echo.
module tb_spi_frame_rx;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned ERR_W       = 8;
    localparam int unsigned LAT         = SYNC_STAGES + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             spi_sck = 1'b0;
    logic             spi_cs_n = 1'b1;
    logic             spi_mosi = 1'b0;
    logic             err_clr = 1'b0;
    logic [7:0]       pwm_val_r, pwm_val_g, pwm_val_b;
    logic             pwm_en, wr_stb;
    logic [ERR_W-1:0] err_cnt;
`ifdef SPI_FRAME_RX_MISO_EN
    logic             spi_miso;
`endif

    spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .FRAME_W(16), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .pwm_val_r(pwm_val_r), .pwm_val_g(pwm_val_g), .pwm_val_b(pwm_val_b),
        .pwm_en(pwm_en), .wr_stb(wr_stb), .err_clr(err_clr), .err_cnt(err_cnt)
`ifdef SPI_FRAME_RX_MISO_EN
        , .spi_miso(spi_miso)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned stb_cnt = 0;
    int unsigned en_bad = 0;
    bit          in_frame = 1'b0;

    // Reference model state
    logic [7:0]  m_r = 8'hFF, m_g = 8'hFF, m_b = 8'hFF;
    logic [7:0]  p_r, p_g, p_b;
    int unsigned m_err = 0;
    logic [15:0] m_echo = 16'h0;
    bit          m_wr;

    always @(negedge clk) begin
        if (wr_stb) stb_cnt++;
        if (in_frame && pwm_en) en_bad++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Frame-level rules: exactly 16 bits with a known address writes a duty
    // register; everything else counts as an error (saturating).
    task automatic model_frame(input logic [31:0] data, input int unsigned nbits);
        p_r = m_r; p_g = m_g; p_b = m_b;
        m_wr = 1'b0;
        if (nbits == 16) begin
            case (data[15:8])
                8'd1: begin m_r = data[7:0]; m_wr = 1'b1; end
                8'd2: begin m_g = data[7:0]; m_wr = 1'b1; end
                8'd3: begin m_b = data[7:0]; m_wr = 1'b1; end
                default: if (m_err < 255) m_err++;
            endcase
            if (m_wr) m_echo = data[15:0];
        end else if (m_err < 255) begin
            m_err++;
        end
    endtask

    // sck = clk/8; mosi changes with the sck falling edge, LSB first.
    // With tail set, one extra sck rise coincides with the cs_n rise.
    task automatic send_frame(input logic [31:0] data, input int unsigned nbits,
                              input bit tail, input int unsigned gap);
        spi_sck = 1'b0;
        cyc(gap);
        spi_cs_n = 1'b0;
        cyc(4);
        in_frame = 1'b1;
        for (int unsigned i = 0; i < nbits; i++) begin
            spi_mosi = data[i];
            spi_sck  = 1'b0;
            cyc(4);
`ifdef SPI_FRAME_RX_MISO_EN
            if (i < 16) check("miso_bit", spi_miso, m_echo[i]);
`endif
            spi_sck = 1'b1;
            cyc(4);
        end
        spi_sck = 1'b0;
        cyc(4);
        if (tail) begin
            spi_mosi = 1'($urandom_range(0, 1));
            spi_sck  = 1'b1;
        end
        spi_cs_n = 1'b1;
        in_frame = 1'b0;
        model_frame(data, nbits);
    endtask

    // Called right after cs_n rises at the pin: nothing may change before
    // SYNC_STAGES+2 edges, then the write (if any) lands with a single wr_stb.
    task automatic check_commit();
        for (int unsigned k = 1; k < LAT; k++) begin
            cyc(1);
            check("wr_stb_early", wr_stb, 0);
            check("r_hold_early", pwm_val_r, p_r);
            check("g_hold_early", pwm_val_g, p_g);
            check("b_hold_early", pwm_val_b, p_b);
        end
        cyc(1);
        check("wr_stb_lat", wr_stb, m_wr);
        check("val_r", pwm_val_r, m_r);
        check("val_g", pwm_val_g, m_g);
        check("val_b", pwm_val_b, m_b);
        check("err_cnt", err_cnt, m_err);
        cyc(1);
        check("wr_stb_single", wr_stb, 0);
        check("pwm_en_idle", pwm_en, 1);
    endtask

    initial begin
        int unsigned s0;
        logic [31:0] data;
        logic [7:0]  addr;
        int unsigned nb;

        // Reset release, no traffic
        cyc(3);
        rst = 1'b0;
        cyc(20);
        check("rst_r", pwm_val_r, 8'hFF);
        check("rst_g", pwm_val_g, 8'hFF);
        check("rst_b", pwm_val_b, 8'hFF);
        check("rst_en", pwm_en, 1);
        check("rst_err", err_cnt, 0);
        check("rst_no_stb", stb_cnt, 0);
`ifdef SPI_FRAME_RX_MISO_EN
        check("rst_miso", spi_miso, 0);
`endif

        // Green write, pwm_en low throughout the frame
        en_bad = 0;
        send_frame(32'h0000_0240, 16, 1'b0, 2);
        check_commit();
        check("pwm_en_low_frame", en_bad, 0);

        // Short then overrun frame
        send_frame(32'h0000_0155, 15, 1'b0, 2);
        check_commit();
        send_frame(32'h0001_0177, 17, 1'b0, 2);
        check_commit();
        check("err_two", err_cnt, 2);

        // Unknown address
        send_frame(32'h0000_0711, 16, 1'b0, 2);
        check_commit();

        // Back-to-back, 2-cycle cs_n gap
        s0 = stb_cnt;
        send_frame(32'h0000_0110, 16, 1'b0, 2);
        send_frame(32'h0000_03C8, 16, 1'b0, 2);
        cyc(10);
        check("b2b_r", pwm_val_r, 8'h10);
        check("b2b_b", pwm_val_b, 8'hC8);
        check("b2b_stb", stb_cnt - s0, 2);

        // 1-cycle gap: the next cs_n fall lands during COMMIT
        s0 = stb_cnt;
        send_frame(32'h0000_0233, 16, 1'b0, 1);
        send_frame(32'h0000_0144, 16, 1'b0, 1);
        cyc(10);
        check("pend_g", pwm_val_g, 8'h33);
        check("pend_r", pwm_val_r, 8'h44);
        check("pend_stb", stb_cnt - s0, 2);

        // sck rise coincident with cs_n rise is discarded
        send_frame(32'h0000_03A5, 16, 1'b1, 2);
        check_commit();

        // Randomized frames
        for (int unsigned n = 0; n < 12; n++) begin
            addr = ($urandom_range(0, 4) < 3) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
            data = {16'h0, addr, 8'($urandom_range(0, 255))};
            data[16] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       nb = 15;
                4:       nb = 17;
                default: nb = 16;
            endcase
            send_frame(data, nb, 1'($urandom_range(0, 1)), 2);
            check_commit();
        end

        // Reset mid-frame after bit 9 of an addr-1 frame
        data = 32'h0000_01AB;
        spi_sck = 1'b0;
        cyc(2);
        spi_cs_n = 1'b0;
        cyc(4);
        for (int unsigned i = 0; i < 10; i++) begin
            spi_mosi = data[i]; spi_sck = 1'b0; cyc(4);
            spi_sck = 1'b1; cyc(4);
        end
        rst = 1'b1;
        #1;
        m_r = 8'hFF; m_g = 8'hFF; m_b = 8'hFF; m_err = 0; m_echo = 16'h0;
        check("mid_rst_r", pwm_val_r, m_r);
        check("mid_rst_g", pwm_val_g, m_g);
        check("mid_rst_b", pwm_val_b, m_b);
        check("mid_rst_en", pwm_en, 0);
        check("mid_rst_stb", wr_stb, 0);
        check("mid_rst_err", err_cnt, m_err);
        cyc(2);
        rst = 1'b0;
        s0 = stb_cnt;
        for (int unsigned i = 10; i < 16; i++) begin
            spi_mosi = data[i]; spi_sck = 1'b0; cyc(4);
            spi_sck = 1'b1; cyc(4);
        end
        spi_sck = 1'b0;
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(10);
        check("post_rst_no_stb", stb_cnt - s0, 0);
        check("post_rst_r", pwm_val_r, 8'hFF);
        check("post_rst_err", err_cnt, 0);
        check("post_rst_en", pwm_en, 1);

        // Commit 0x015A, then another frame (echoes 0x015A when MISO is built in)
        send_frame(32'h0000_015A, 16, 1'b0, 2);
        check_commit();
        send_frame({16'h0, 8'h02, 8'($urandom_range(0, 255))}, 16, 1'b0, 2);
        check_commit();

        // Saturation of err_cnt
        for (int unsigned n = 0; n < 260; n++) begin
            send_frame(32'h0, 0, 1'b0, 2);
            cyc(6);
        end
        check("err_sat", err_cnt, m_err);
        check("err_sat_ones", err_cnt, 255);

        // err_clr coincident with a REJECT increment
        send_frame(32'h0, 0, 1'b0, 2);
        cyc(LAT - 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        m_err = 0;
        check("err_clr_prio", err_cnt, m_err);
        cyc(3);
        check("err_clr_hold", err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
